// File: rtl/add16_arb_pkg.sv
// add16_arb_pkg: shared types for add16_arbiter (flag fields exist only when ADD16_ARB_FLAGS_EN is defined)
package add16_arb_pkg;
    localparam int WORD_W   = 16;
    localparam int ID_MAX_W = 3;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic {EMPTY, FULL} out_state_e;
    typedef struct packed {
        word_t               sum;
        logic [ID_MAX_W-1:0] id;
`ifdef ADD16_ARB_FLAGS_EN
        logic                cout;
        logic                ovf;
`endif
    } rsp_t;
endpackage

// File: rtl/ADD16.sv
// ADD16: 16-bit ripple-carry adder; ports x, y, cin in, sum out (no carry-out port)
module ADD16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] sum
);
    logic carry;
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < 16; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | ((x[i] ^ y[i]) & carry);
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr/en in, one-hot gnt and binary gnt_idx out
module rr_arbiter
    import add16_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] idx;
    // Scan from farthest to nearest so the last hit is the first valid index at/after ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (en && req[idx]) begin
                gnt     = N'(1) << idx;
                gnt_idx = idx;
            end
        end
    end
endmodule

// File: rtl/add16_arbiter.sv
// add16_arbiter: round-robin sharing of one ADD16 among N_REQ requesters with a registered, tagged response
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_x/req_y per requester;
//        rsp_valid/rsp_ready/rsp_sum/rsp_id response stream; busy; rsp_cout/rsp_ovf when ADD16_ARB_FLAGS_EN is defined
module add16_arbiter
    import add16_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*WORD_W-1:0]   req_x,
    input  logic [N_REQ*WORD_W-1:0]   req_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WORD_W-1:0]         rsp_sum,
    output logic [ID_W-1:0]           rsp_id,
`ifdef ADD16_ARB_FLAGS_EN
    output logic                      rsp_cout,
    output logic                      rsp_ovf,
`endif
    output logic                      busy
);
    out_state_e       state, state_d;
    rsp_t             rsp_q, rsp_new;
    logic [ID_W-1:0]  ptr, gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             can_accept, xfer;
    word_t            x_sel, y_sel, sum;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_d;
    end

    always_comb state_d = (xfer || (state == FULL && !rsp_ready)) ? FULL : EMPTY;

    always_comb begin
        rsp_valid  = state == FULL;
        can_accept = !rsp_valid || rsp_ready;
        busy       = rsp_valid || |req_valid;
    end

    // Gating with rst keeps a request from being accepted in the reset cycle.
    rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (can_accept && !rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign x_sel     = req_x[WORD_W*gnt_idx +: WORD_W];
    assign y_sel     = req_y[WORD_W*gnt_idx +: WORD_W];

    ADD16 u_add (.x(x_sel), .y(y_sel), .cin(1'b0), .sum(sum));

    always_comb begin
        rsp_new     = '0;
        rsp_new.sum = sum;
        rsp_new.id  = ID_MAX_W'(gnt_idx);
`ifdef ADD16_ARB_FLAGS_EN
        // ADD16 has no carry-out, so rebuild it from the top bit of operands and sum.
        rsp_new.cout = (x_sel[15] & y_sel[15]) | ((x_sel[15] ^ y_sel[15]) & ~sum[15]);
        rsp_new.ovf  = (x_sel[15] == y_sel[15]) && (sum[15] != x_sel[15]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
            ptr   <= '0;
        end else if (xfer) begin
            rsp_q <= rsp_new;
            ptr   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign rsp_sum = rsp_q.sum;
    assign rsp_id  = ID_W'(rsp_q.id);
`ifdef ADD16_ARB_FLAGS_EN
    assign rsp_cout = rsp_q.cout;
    assign rsp_ovf  = rsp_q.ovf;
`endif
endmodule

// File: tb/tb_add16_arbiter.sv
// tb_add16_arbiter: randomized self-checking bench for add16_arbiter against a behavioural model
module tb_add16_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_x, req_y;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef ADD16_ARB_FLAGS_EN
    logic        rsp_cout, rsp_ovf;
`endif
    logic [15:0] ox [4];
    logic [15:0] oy [4];

    always #5 clk = ~clk;

    assign req_x = {ox[3], ox[2], ox[1], ox[0]};
    assign req_y = {oy[3], oy[2], oy[1], oy[0]};

    add16_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
`ifdef ADD16_ARB_FLAGS_EN
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the response register and arbitration pointer.
    bit          m_valid = 0;
    logic [15:0] m_sum = '0;
    int          m_id = 0;
    int          m_ptr = 0;
    bit          m_cout = 0;
    bit          m_ovf = 0;
    logic [3:0]  exp_ready, obs_ready;
    bit          exp_busy, obs_busy;

    function automatic logic [3:0] pick(logic [3:0] v, int p, bit can);
        if (!can) return 4'b0;
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return 4'b0001 << ((p + k) % 4);
        return 4'b0;
    endfunction

    task automatic renew(int i);
        ox[i] = 16'($urandom);
        oy[i] = 16'($urandom);
    endtask

    // Samples the combinational outputs mid-cycle, then advances clock and model by one edge.
    task automatic cycle();
        int g, full, s;
        #4;
        exp_ready = pick(req_valid, m_ptr, !rst && (!m_valid || rsp_ready));
        exp_busy  = m_valid || (|req_valid);
        obs_ready = req_ready;
        obs_busy  = busy;
        g = -1;
        for (int i = 0; i < 4; i++) if (exp_ready[i]) g = i;
        if (rst) begin
            m_valid = 0; m_sum = '0; m_id = 0; m_ptr = 0; m_cout = 0; m_ovf = 0;
        end else if (g >= 0) begin
            full    = int'(ox[g]) + int'(oy[g]);
            s       = int'($signed(ox[g])) + int'($signed(oy[g]));
            m_sum   = full[15:0];
            m_cout  = full > 65535;
            m_ovf   = (s > 32767) || (s < -32768);
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % 4;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 4'hF; rsp_ready = 1;
        for (int i = 0; i < 4; i++) renew(i);
        repeat (2) begin
            cycle();
            n_vec++;
            if (obs_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
        end
        n_vec += 3;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        if (rsp_sum !== 16'h0) begin n_err++; $display("FAIL reset_sum: got %h want 0000", rsp_sum); end
        if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        rst = 0; req_valid = 4'h0;
    endtask

    task automatic test_single();
        req_valid = 4'b0010; ox[1] = 16'h1234; oy[1] = 16'h0101; rsp_ready = 0;
        cycle();
        n_vec += 4;
        if (obs_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready: got %b want 0010", obs_ready); end
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        if (rsp_sum !== 16'h1335) begin n_err++; $display("FAIL single_sum: got %h want 1335", rsp_sum); end
        if (rsp_id !== 2'd1) begin n_err++; $display("FAIL single_id: got %0d want 1", rsp_id); end
        req_valid = 4'b0; rsp_ready = 1;
        cycle();
        n_vec += 3;
        if (obs_busy !== 1'b1) begin n_err++; $display("FAIL drain_busy: got %b want 1", obs_busy); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", rsp_valid); end
        if (rsp_sum !== 16'h1335) begin n_err++; $display("FAIL drain_hold_sum: got %h want 1335", rsp_sum); end
        cycle();
        n_vec++;
        if (obs_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", obs_busy); end
    endtask

    task automatic test_round_robin();
        rst = 1; cycle(); rst = 0;
        req_valid = 4'hF; rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec += 4;
            if (obs_ready !== (4'b0001 << (i % 4))) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, obs_ready, 4'b0001 << (i % 4)); end
            if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", i, rsp_valid); end
            if (rsp_id !== 2'(i % 4)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, rsp_id, i % 4); end
            if (rsp_sum !== m_sum) begin n_err++; $display("FAIL rr_sum[%0d]: got %h want %h", i, rsp_sum, m_sum); end
            renew(i % 4);
        end
    endtask

    task automatic test_stall();
        logic [15:0] held_sum;
        logic [1:0]  held_id;
        held_sum = m_sum; held_id = 2'(m_id);
        rsp_ready = 0;
        repeat (3) begin
            cycle();
            n_vec += 4;
            if (obs_ready !== 4'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0000", obs_ready); end
            if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", rsp_valid); end
            if (rsp_sum !== held_sum) begin n_err++; $display("FAIL stall_sum: got %h want %h", rsp_sum, held_sum); end
            if (rsp_id !== held_id) begin n_err++; $display("FAIL stall_id: got %0d want %0d", rsp_id, held_id); end
        end
        rsp_ready = 1;
        cycle();
        n_vec += 4;
        if (obs_ready !== 4'b0010) begin n_err++; $display("FAIL release_ready: got %b want 0010", obs_ready); end
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL release_valid: got %b want 1", rsp_valid); end
        if (rsp_id !== 2'd1) begin n_err++; $display("FAIL release_id: got %0d want 1", rsp_id); end
        if (rsp_sum !== m_sum) begin n_err++; $display("FAIL release_sum: got %h want %h", rsp_sum, m_sum); end
        renew(1);
    endtask

    task automatic test_wrap();
        req_valid = 4'b0001; ox[0] = 16'hFFFF; oy[0] = 16'h0001; rsp_ready = 1;
        cycle();
        n_vec += 2;
        if (rsp_sum !== 16'h0000) begin n_err++; $display("FAIL wrap_sum: got %h want 0000", rsp_sum); end
        if (rsp_id !== 2'd0) begin n_err++; $display("FAIL wrap_id: got %0d want 0", rsp_id); end
`ifdef ADD16_ARB_FLAGS_EN
        n_vec += 2;
        if (rsp_cout !== 1'b1) begin n_err++; $display("FAIL wrap_cout: got %b want 1", rsp_cout); end
        if (rsp_ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf: got %b want 0", rsp_ovf); end
`endif
        req_valid = 4'b0100; ox[2] = 16'h7FFF; oy[2] = 16'h0001;
        cycle();
        n_vec += 2;
        if (rsp_sum !== 16'h8000) begin n_err++; $display("FAIL ovf_sum: got %h want 8000", rsp_sum); end
        if (rsp_id !== 2'd2) begin n_err++; $display("FAIL ovf_id: got %0d want 2", rsp_id); end
`ifdef ADD16_ARB_FLAGS_EN
        n_vec += 2;
        if (rsp_cout !== 1'b0) begin n_err++; $display("FAIL ovf_cout: got %b want 0", rsp_cout); end
        if (rsp_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_ovf: got %b want 1", rsp_ovf); end
`endif
        req_valid = 4'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) renew(i);
        req_valid = 4'hF; rsp_ready = 0;
        cycle();
        n_vec++;
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", rsp_valid); end
        rst = 1;
        cycle();
        n_vec += 2;
        if (obs_ready !== 4'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0000", obs_ready); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
        rst = 0; req_valid = 4'b1010; rsp_ready = 1;
        cycle();
        n_vec += 3;
        if (obs_ready !== 4'b0010) begin n_err++; $display("FAIL mid_first_ready: got %b want 0010", obs_ready); end
        if (rsp_id !== 2'd1) begin n_err++; $display("FAIL mid_first_id: got %0d want 1", rsp_id); end
        if (rsp_sum !== m_sum) begin n_err++; $display("FAIL mid_first_sum: got %h want %h", rsp_sum, m_sum); end
        renew(1); req_valid = 4'b0;
        cycle();
    endtask

    task automatic test_fairness();
        int others = 0;
        req_valid = 4'b1000;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) if (!req_valid[i] && $urandom_range(0, 1) == 1) req_valid[i] = 1'b1;
            rsp_ready = $urandom_range(0, 3) != 0;
            cycle();
            n_vec += 3;
            if (obs_ready !== exp_ready) begin n_err++; $display("FAIL fair_ready[%0d]: got %b want %b", c, obs_ready, exp_ready); end
            if (obs_busy !== exp_busy) begin n_err++; $display("FAIL fair_busy[%0d]: got %b want %b", c, obs_busy, exp_busy); end
            if (rsp_valid !== m_valid) begin n_err++; $display("FAIL fair_valid[%0d]: got %b want %b", c, rsp_valid, m_valid); end
            if (m_valid) begin
                n_vec += 2;
                if (rsp_sum !== m_sum) begin n_err++; $display("FAIL fair_sum[%0d]: got %h want %h", c, rsp_sum, m_sum); end
                if (rsp_id !== 2'(m_id)) begin n_err++; $display("FAIL fair_id[%0d]: got %0d want %0d", c, rsp_id, m_id); end
`ifdef ADD16_ARB_FLAGS_EN
                n_vec += 2;
                if (rsp_cout !== m_cout) begin n_err++; $display("FAIL fair_cout[%0d]: got %b want %b", c, rsp_cout, m_cout); end
                if (rsp_ovf !== m_ovf) begin n_err++; $display("FAIL fair_ovf[%0d]: got %b want %b", c, rsp_ovf, m_ovf); end
`endif
            end
            if (|obs_ready) begin
                if (obs_ready[3]) others = 0;
                else others++;
                n_vec++;
                if (others > 3) begin n_err++; $display("FAIL fair_starve[%0d]: got %0d other grants want <=3", c, others); end
                for (int i = 0; i < 4; i++) if (obs_ready[i]) begin
                    renew(i);
                    if (i < 3) req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = 4'b0;
    endtask

    initial begin
        rst = 1; req_valid = '0; rsp_ready = 0;
        for (int i = 0; i < 4; i++) renew(i);
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
